zeroriscy_instr_stub_resp: RTL and testbench

- Instruction-fetch responder, i.e. the memory side of the core's instr_req/gnt/rvalid fetch interface.
- Encodes queued abstract commands into RV32I instruction words using the codebase opcode constants and returns them to the core's fetch unit with a fixed response latency.
- Used as a boot/test stub in place of instruction memory in core-level benches and small SoC configs.

---
 rtl/zeroriscy_instr_stub_resp.sv | 161 ++++++++++++++++
 tb/tb_zeroriscy_instr_stub_resp.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zeroriscy_instr_stub_resp.sv
// Instruction-fetch stub: encodes queued abstract commands into RV32I words and
// answers instr_req with a fixed latency. Optional ZERORISCY_STUB_SEQ_CHECK_EN adds a sticky fetch-address sequence check.
module zeroriscy_instr_stub_resp #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_kind_i,
  input  logic [4:0]  cmd_rd_i,
  input  logic [4:0]  cmd_rs1_i,
  input  logic [4:0]  cmd_rs2_i,
  input  logic [2:0]  cmd_funct3_i,
  input  logic        cmd_alt_i,
  input  logic [20:0] cmd_imm_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] fetch_cnt_o,
  output logic        seq_err_o
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef enum logic [2:0] {
    K_OP, K_OPIMM, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_LUI, K_SYSTEM
  } kind_e;

  typedef struct packed {
    kind_e       kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        alt;
    logic [20:0] imm;
  } cmd_t;

  function automatic logic [31:0] encode(cmd_t c);
    logic [31:0] w;
    w = NOP;
    case (c.kind)
      K_OP:     w = {1'b0, c.alt, 5'b0, c.rs2, c.rs1, c.f3, c.rd, OPC_OP};
      K_OPIMM: begin
        w = {c.imm[11:0], c.rs1, c.f3, c.rd, OPC_OPIMM};
        // SRAI/SRLI select lives in bit 30, overriding that immediate bit
        if (c.f3 == 3'b101) w[30] = c.alt;
      end
      K_LOAD:   w = {c.imm[11:0], c.rs1, c.f3, c.rd, OPC_LOAD};
      K_STORE:  w = {c.imm[11:5], c.rs2, c.rs1, c.f3, c.imm[4:0], OPC_STORE};
      K_BRANCH: w = {c.imm[12], c.imm[10:5], c.rs2, c.rs1, c.f3, c.imm[4:1], c.imm[11], OPC_BRANCH};
      K_JAL:    w = {c.imm[20], c.imm[10:1], c.imm[11], c.imm[19:12], c.rd, OPC_JAL};
      K_LUI:    w = {c.imm[19:0], c.rd, OPC_LUI};
      K_SYSTEM: w = {c.imm[11:0], 13'b0, OPC_SYSTEM};
      default:  w = NOP;
    endcase
    return w;
  endfunction

  cmd_t          mem [DEPTH];
  cmd_t          cmd_in;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, push, pop;
  logic          busy;
  logic [1:0]    lat_cnt;
  logic [31:0]   word_q, word_d, fetch_cnt;
  logic          rvalid;

  assign cmd_in = '{kind: kind_e'(cmd_kind_i), rd: cmd_rd_i, rs1: cmd_rs1_i, rs2: cmd_rs2_i,
                    f3: cmd_funct3_i, alt: cmd_alt_i, imm: cmd_imm_i};

  assign full        = (count == (AW+1)'(DEPTH));
  assign cmd_ready_o = !full;
  assign push        = cmd_valid_i && !full;
  assign rvalid      = busy && (lat_cnt == 2'd0);
  assign instr_gnt_o = instr_req_i && !rst && (!busy || rvalid);
  assign pop         = instr_gnt_o && (count != '0);
  assign word_d      = (count != '0) ? encode(mem[rptr]) : NOP;

  assign instr_rvalid_o = rvalid;
  assign instr_rdata_o  = rvalid ? word_q : 32'h0;
  assign fetch_cnt_o    = fetch_cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= cmd_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A grant in the rvalid cycle reloads the counter, keeping back-to-back fetches busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      lat_cnt   <= 2'd0;
      word_q    <= 32'h0;
      fetch_cnt <= 32'h0;
    end else if (instr_gnt_o) begin
      busy      <= 1'b1;
      lat_cnt   <= 2'(LATENCY - 1);
      word_q    <= word_d;
      fetch_cnt <= fetch_cnt + 32'd1;
    end else if (rvalid) begin
      busy <= 1'b0;
    end else if (busy) begin
      lat_cnt <= lat_cnt - 2'd1;
    end
  end

`ifdef ZERORISCY_STUB_SEQ_CHECK_EN
  logic [31:0] exp_addr;
  logic        chk_en, seq_err;

  // A taken control-flow word makes the following address unpredictable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_addr <= 32'h0;
      chk_en   <= 1'b0;
      seq_err  <= 1'b0;
    end else if (instr_gnt_o) begin
      if (chk_en && (instr_addr_i != exp_addr)) seq_err <= 1'b1;
      exp_addr <= instr_addr_i + 32'd4;
      chk_en   <= !((word_d[6:0] == OPC_BRANCH) || (word_d[6:0] == OPC_JAL));
    end
  end

  assign seq_err_o = seq_err;
`else
  logic unused_addr;
  assign unused_addr = ^instr_addr_i;
  assign seq_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_zeroriscy_instr_stub_resp.sv
// Bench for zeroriscy_instr_stub_resp: LATENCY=1 and LATENCY=3 instances share stimulus,
// each checked every cycle against a queue-based model, plus hand-computed literal words.
module tb_zeroriscy_instr_stub_resp;
  typedef struct packed {
    logic [2:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        alt;
    logic [20:0] imm;
  } cmd_t;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  cmd_t        cmd;
  logic        req;
  logic [31:0] addr;

  logic        ready  [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic        serr   [2];
  logic [31:0] rdata  [2];
  logic [31:0] fcnt   [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(int k, int rd, int rs1, int rs2, int f3, int alt, int imm);
    cmd_t c;
    c.kind = 3'(k); c.rd = 5'(rd); c.rs1 = 5'(rs1); c.rs2 = 5'(rs2);
    c.f3 = 3'(f3); c.alt = 1'(alt); c.imm = 21'(imm);
    return c;
  endfunction

  // Field placement by shift-and-mask straight from the RV32I formats
  function automatic logic [31:0] enc(cmd_t c);
    logic [31:0] im, rd, r1, r2, f3, w;
    im = 32'(c.imm); rd = 32'(c.rd) << 7; r1 = 32'(c.rs1) << 15;
    r2 = 32'(c.rs2) << 20; f3 = 32'(c.f3) << 12;
    case (c.kind)
      3'd0: w = (32'(c.alt) << 30) | r2 | r1 | f3 | rd | 32'h33;
      3'd1: begin
        w = ((im & 32'hfff) << 20) | r1 | f3 | rd | 32'h13;
        if (c.f3 == 3'd5) w = (w & ~(32'h1 << 30)) | (32'(c.alt) << 30);
      end
      3'd2: w = ((im & 32'hfff) << 20) | r1 | f3 | rd | 32'h03;
      3'd3: w = (((im >> 5) & 32'h7f) << 25) | r2 | r1 | f3 | ((im & 32'h1f) << 7) | 32'h23;
      3'd4: w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3f) << 25) | r2 | r1 | f3 |
                (((im >> 1) & 32'hf) << 8) | (((im >> 11) & 1) << 7) | 32'h63;
      3'd5: w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3ff) << 21) |
                (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hff) << 12) | rd | 32'h6f;
      3'd6: w = ((im & 32'hfffff) << 12) | rd | 32'h37;
      default: w = ((im & 32'hfff) << 20) | 32'h73;
    endcase
    return w;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = (g == 0) ? 1 : 3;

    zeroriscy_instr_stub_resp #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(ready[g]),
      .cmd_kind_i(cmd.kind), .cmd_rd_i(cmd.rd), .cmd_rs1_i(cmd.rs1), .cmd_rs2_i(cmd.rs2),
      .cmd_funct3_i(cmd.f3), .cmd_alt_i(cmd.alt), .cmd_imm_i(cmd.imm),
      .instr_req_i(req), .instr_addr_i(addr),
      .instr_gnt_o(gnt[g]), .instr_rvalid_o(rvalid[g]), .instr_rdata_o(rdata[g]),
      .fetch_cnt_o(fcnt[g]), .seq_err_o(serr[g])
    );

    cmd_t        q[$];
    bit          pend = 0;
    int          due = 0;
    int          cyc = 0;
    logic [31:0] pword = '0;
    logic [31:0] mcnt = '0;
    bit          merr = 0;
`ifdef ZERORISCY_STUB_SEQ_CHECK_EN
    bit          chk = 0;
    logic [31:0] eaddr = '0;
`endif

    always @(negedge clk) begin : mdl
      bit rv_e, g_e, rdy_e, jump;
      logic [31:0] w;
      cmd_t c;
      cyc++;
      if (rst) begin
        check($sformatf("i%0d reset ready", g), 32'(ready[g]), 1);
        check($sformatf("i%0d reset gnt", g), 32'(gnt[g]), 0);
        check($sformatf("i%0d reset rvalid", g), 32'(rvalid[g]), 0);
        check($sformatf("i%0d reset rdata", g), rdata[g], 0);
        check($sformatf("i%0d reset fetch_cnt", g), fcnt[g], 0);
        check($sformatf("i%0d reset seq_err", g), 32'(serr[g]), 0);
        q.delete(); pend = 0; mcnt = 0; merr = 0;
`ifdef ZERORISCY_STUB_SEQ_CHECK_EN
        chk = 0;
`endif
      end else begin
        rv_e  = pend && (cyc == due);
        g_e   = req && (!pend || rv_e);
        rdy_e = (q.size() < DEPTH);
        check($sformatf("i%0d gnt", g), 32'(gnt[g]), 32'(g_e));
        check($sformatf("i%0d rvalid", g), 32'(rvalid[g]), 32'(rv_e));
        check($sformatf("i%0d rdata", g), rdata[g], rv_e ? pword : 32'h0);
        check($sformatf("i%0d fetch_cnt", g), fcnt[g], mcnt);
        check($sformatf("i%0d cmd_ready", g), 32'(ready[g]), 32'(rdy_e));
        check($sformatf("i%0d seq_err", g), 32'(serr[g]), 32'(merr));
        if (rv_e) pend = 0;
        if (g_e) begin
          jump = 0;
          if (q.size() > 0) begin
            c = q.pop_front();
            w = enc(c);
            jump = (c.kind == 3'd4) || (c.kind == 3'd5);
          end else begin
            w = 32'h13;
          end
          pend = 1; due = cyc + LAT; pword = w; mcnt = mcnt + 1;
`ifdef ZERORISCY_STUB_SEQ_CHECK_EN
          if (chk && addr != eaddr) merr = 1;
          eaddr = addr + 4;
          chk   = !jump;
`endif
        end
        if (cmd_valid && rdy_e) q.push_back(cmd);
      end
    end
  end

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input cmd_t c);
    cmd_valid = 1'b1; cmd = c;
    next();
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [6:0] gpat, rpat;
    rst = 1'b1; cmd_valid = 1'b0; cmd = '0; req = 1'b0; addr = '0;
    smp();
    check("lit reset ready", 32'(ready[0]), 1);
    check("lit reset fetch_cnt", fcnt[0], 0);
    next(); rst = 1'b0;

    // ADDI x1,x0,5 fetched at 0x80
    push(mk(1, 1, 0, 0, 0, 0, 5));
    req = 1'b1; addr = 32'h80;
    smp(); check("lit first gnt", 32'(gnt[0]), 1);
    next(); req = 1'b0;
    smp();
    check("lit first rvalid", 32'(rvalid[0]), 1);
    check("lit addi word", rdata[0], 32'h0050_0093);
    check("lit fetch_cnt 1", fcnt[0], 1);
    next();

    // LUI then ADD, back-to-back fetches
    push(mk(6, 2, 0, 0, 0, 0, 32'h12345));
    push(mk(0, 3, 1, 2, 0, 0, 0));
    req = 1'b1; addr = 32'h84;
    smp(); check("lit b2b gnt0", 32'(gnt[0]), 1);
    next(); addr = 32'h88;
    smp();
    check("lit b2b gnt1", 32'(gnt[0]), 1);
    check("lit lui word", rdata[0], 32'h1234_5137);
    next(); req = 1'b0;
    smp(); check("lit add word", rdata[0], 32'h0020_81B3);
    next();

    // SW, JAL, ECALL; JAL redirects fetch to 0x200
    push(mk(3, 0, 0, 3, 2, 0, 4));
    push(mk(5, 0, 0, 0, 0, 0, 0));
    push(mk(7, 0, 0, 0, 0, 0, 0));
    req = 1'b1; addr = 32'h8c;
    next(); addr = 32'h90;
    smp(); check("lit store word", rdata[0], 32'h0030_2223);
    next(); addr = 32'h200;
    smp(); check("lit jal word", rdata[0], 32'h0000_006F);
    next(); req = 1'b0;
    smp(); check("lit system word", rdata[0], 32'h0000_0073);
`ifdef ZERORISCY_STUB_SEQ_CHECK_EN
    check("lit no seq_err after jal", 32'(serr[0]), 0);
`endif
    next();

    // Empty FIFO -> NOP; command pushed in that grant cycle is kept for the next fetch
    req = 1'b1; addr = 32'h204;
    next(); req = 1'b0;
    smp(); check("lit empty nop", rdata[0], 32'h0000_0013);
    next();
    req = 1'b1; addr = 32'h208; cmd_valid = 1'b1; cmd = mk(0, 6, 7, 8, 0, 1, 0);
    next(); cmd_valid = 1'b0; addr = 32'h20c;
    smp(); check("lit nop with push", rdata[0], 32'h0000_0013);
    next(); req = 1'b0;
    smp(); check("lit sub word", rdata[0], 32'h4083_8333);
    next();

    // Fill to 3, push+grant keeps count, one more push fills the FIFO
    push(mk(4, 0, 1, 2, 1, 0, -8));
    push(mk(1, 4, 4, 0, 5, 1, 3));
    push(mk(2, 5, 2, 0, 2, 0, 32'h7fc));
    cmd_valid = 1'b1; cmd = mk(0, 9, 9, 9, 0, 0, 0); req = 1'b1; addr = 32'h210;
    smp(); check("lit ready at 3", 32'(ready[0]), 1);
    next(); cmd_valid = 1'b0; req = 1'b0;
    smp();
    check("lit ready after push+pop", 32'(ready[0]), 1);
    check("lit bne word", rdata[0], 32'hFE20_9CE3);
    next();
    push(mk(0, 10, 10, 10, 0, 0, 0));
    smp(); check("lit full ready", 32'(ready[0]), 0);
    next();
    push(mk(0, 11, 11, 11, 0, 0, 0));
    req = 1'b1; addr = 32'h214;
    next(); addr = 32'h218;
    smp(); check("lit srai word", rdata[0], 32'h4032_5213);
    for (int i = 0; i < 4; i++) begin
      next(); addr = addr + 32'd4;
    end
    req = 1'b0;
    repeat (5) next();

    // Request held high: LATENCY=3 grants every third cycle, in the rvalid cycle
    gpat = 7'b1001001; rpat = 7'b1001000;
    req = 1'b1; addr = 32'h400;
    for (int i = 0; i < 7; i++) begin
      smp();
      check($sformatf("lit lat3 gnt c%0d", i), 32'(gnt[1]), 32'(gpat[i]));
      check($sformatf("lit lat3 rvalid c%0d", i), 32'(rvalid[1]), 32'(rpat[i]));
      next(); addr = addr + 32'd4;
    end
    req = 1'b0;
    repeat (5) next();

    // Reset one cycle after a grant drops the pending response
    req = 1'b1; addr = 32'h300;
    next(); req = 1'b0; rst = 1'b1;
    smp();
    check("lit rst drop rvalid", 32'(rvalid[0]), 0);
    check("lit rst drop rdata", rdata[0], 0);
    check("lit rst drop fetch_cnt", fcnt[0], 0);
    next(); rst = 1'b0;
    repeat (5) next();

    // Address jump 0x80 -> 0x88 without a control-flow word
    req = 1'b1; addr = 32'h80;
    next(); addr = 32'h88;
    next(); req = 1'b0;
`ifdef ZERORISCY_STUB_SEQ_CHECK_EN
    smp(); check("lit seq_err set", 32'(serr[0]), 1);
    repeat (3) next();
    smp(); check("lit seq_err sticky", 32'(serr[0]), 1);
`endif
    repeat (3) next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
